// File: rtl/loader_pkg.sv
// Shared types and helpers for the boot-time program loader.
package loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int LOADER_BYTES_PER_WORD = 3;

  // 8-bit modular running sum; a valid image totals zero including its CSUM byte.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: length header, little-endian word assembly,
// sequential instruction-memory writes and an 8-bit zero-sum checksum.
module prog_loader
  import loader_pkg::*;
#(
  parameter int WORD_SIZE = 20,
  parameter int ADDR_SIZE = 16,
  parameter int MEM_SIZE  = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [WORD_SIZE-1:0] mem_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 cpu_reset_o
);

  loader_state_t state, state_nxt;

  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  sum;
  logic [7:0]  b0, b1;
  logic        accept;
  logic [16:0] len_in;
  logic [16:0] idx_inc;

  assign byte_ready_o = state inside {ST_LEN_LO, ST_LEN_HI, ST_B0, ST_B1, ST_B2, ST_CSUM};
  assign busy_o       = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign done_o       = (state == ST_DONE);
  assign error_o      = (state == ST_ERROR);
  assign cpu_reset_o  = !done_o;

  assign accept  = byte_valid_i & byte_ready_o;
  // Full word count as it will be once LEN_HI lands, so the decision needs no extra cycle.
  assign len_in  = {1'b0, byte_i, len[7:0]};
  assign idx_inc = {1'b0, idx} + 17'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start_i) state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (accept) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (len_in > 17'(MEM_SIZE)) state_nxt = ST_ERROR;
          else if (len_in == 17'd0)   state_nxt = ST_CSUM;
          else                        state_nxt = ST_B0;
        end
      end
      ST_B0:    if (accept) state_nxt = ST_B1;
      ST_B1:    if (accept) state_nxt = ST_B2;
      ST_B2:    if (accept) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = (idx_inc < {1'b0, len}) ? ST_B0 : ST_CSUM;
      ST_CSUM: begin
        if (accept) state_nxt = (csum_add(sum, byte_i) == 8'd0) ? ST_DONE : ST_ERROR;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len        <= '0;
      idx        <= '0;
      sum        <= '0;
      b0         <= '0;
      b1         <= '0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      mem_we_o <= 1'b0;
      if (start_i && !busy_o) begin
        sum <= '0;
        idx <= '0;
      end
      if (accept) begin
        sum <= csum_add(sum, byte_i);
        unique case (state)
          ST_LEN_LO: len[7:0]  <= byte_i;
          ST_LEN_HI: len[15:8] <= byte_i;
          ST_B0:     b0        <= byte_i;
          ST_B1:     b1        <= byte_i;
          // Address/data latch with the strobe so they hold steady for the whole WRITE cycle.
          ST_B2: begin
            mem_we_o   <= 1'b1;
            mem_addr_o <= ADDR_SIZE'(idx);
            mem_data_o <= {byte_i[WORD_SIZE-17:0], b1, b0};
          end
          default: ;
        endcase
      end
      if (state == ST_WRITE) idx <= idx + 16'd1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against an image-level reference model.
module tb_prog_loader;

  localparam int WS = 20;
  localparam int AS = 16;
  localparam int MS = 4096;

  logic          clk, reset, start_i, byte_valid_i;
  logic [7:0]    byte_i;
  logic          byte_ready_o, mem_we_o, busy_o, done_o, error_o, cpu_reset_o;
  logic [AS-1:0] mem_addr_o;
  logic [WS-1:0] mem_data_o;

  prog_loader #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .cpu_reset_o(cpu_reset_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [WS-1:0] wq[$];
  logic [AS-1:0] got_a[$];
  logic [WS-1:0] got_d[$];

  always @(negedge clk) begin
    if (mem_we_o) begin
      got_a.push_back(mem_addr_o);
      got_d.push_back(mem_data_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ready"}, byte_ready_o, 0);
    chk({tag, " we"},    mem_we_o, 0);
    chk({tag, " addr"},  mem_addr_o, 0);
    chk({tag, " data"},  mem_data_o, 0);
    chk({tag, " busy"},  busy_o, 0);
    chk({tag, " done"},  done_o, 0);
    chk({tag, " err"},   error_o, 0);
    chk({tag, " cpurst"}, cpu_reset_o, 1);
  endtask

  // Builds the byte image for the words in wq, streams it, then checks writes and status.
  task automatic load(input string tag, input int nlen, input bit bad, input bit thr,
                      input bit noisy, input bit skip_start, input int abort_at);
    logic [7:0] img[$];
    logic [7:0] s, b2;
    logic [15:0] l16;
    int k, cyc, nexp, target;
    bit acc, exp_err;
    l16 = 16'(nlen);
    img = {};
    img.push_back(l16[7:0]);
    img.push_back(l16[15:8]);
    exp_err = (nlen > MS) || bad;
    nexp = 0;
    if (nlen <= MS) begin
      nexp = nlen;
      for (int i = 0; i < nlen; i++) begin
        b2 = 8'(wq[i] >> 16) | (thr ? (8'($urandom) & 8'hF0) : 8'h00);
        img.push_back(8'(wq[i]));
        img.push_back(8'(wq[i] >> 8));
        img.push_back(b2);
      end
      s = 8'h00;
      foreach (img[i]) s = s + img[i];
      img.push_back(8'(8'h00 - s) + (bad ? 8'd1 : 8'd0));
    end
    if (abort_at > 0) begin
      nexp = (abort_at - 2) / 3;
      if (nexp > nlen) nexp = nlen;
    end
    target = (abort_at > 0) ? abort_at : img.size();
    got_a = {};
    got_d = {};
    if (!skip_start) begin
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    k = 0;
    cyc = 0;
    while (k < target && cyc < 20000) begin
      byte_valid_i = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_i       = img[k];
      start_i      = noisy && busy_o && ($urandom_range(0, 7) == 0);
      acc          = byte_valid_i && byte_ready_o;
      @(negedge clk);
      cyc++;
      if (acc) k++;
    end
    start_i = 1'b0;
    chk({tag, " bytes"}, k, target);
    if (abort_at > 0) begin
      reset = 1'b1;
      byte_valid_i = 1'b0;
      @(negedge clk);
      chk_reset_vals({tag, " abort"});
      reset = 1'b0;
      repeat (10) @(negedge clk);
    end else begin
      chk({tag, " busy"},   busy_o, 0);
      chk({tag, " done"},   done_o, !exp_err);
      chk({tag, " err"},    error_o, exp_err);
      chk({tag, " cpurst"}, cpu_reset_o, exp_err);
      byte_valid_i = 1'b0;
    end
    chk({tag, " nwr"}, got_a.size(), nexp);
    for (int i = 0; i < nexp && i < got_a.size(); i++) begin
      chk($sformatf("%s addr%0d", tag, i), got_a[i], i);
      chk($sformatf("%s data%0d", tag, i), got_d[i], wq[i]);
    end
  endtask

  task automatic rand_words(input int n);
    wq = {};
    for (int i = 0; i < n; i++) wq.push_back(WS'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    start_i = 1'b1;
    byte_valid_i = 1'b0;
    byte_i = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    start_i = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rst idle busy", busy_o, 0);

    wq = {20'h12345, 20'hABCDE};
    load("dir", 2, 0, 0, 0, 0, 0);
    load("badcs", 2, 1, 0, 0, 0, 0);
    wq = {};
    load("n0", 0, 0, 0, 0, 0, 0);
    load("over", MS + 1, 0, 0, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      rand_words(n);
      load($sformatf("rnd%0d", r), n, (r == 5), r[0], 1, 0, 0);
    end

    rand_words(3);
    load("pre", 3, 0, 0, 0, 0, 0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("restart done",   done_o, 0);
    chk("restart cpurst", cpu_reset_o, 1);
    chk("restart busy",   busy_o, 1);
    rand_words(4);
    load("post", 4, 0, 1, 0, 1, 0);

    rand_words(10);
    load("abort", 10, 0, 1, 0, 0, 13);
    rand_words(10);
    load("reload", 10, 0, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
